// File: rtl/priv_1_12_irq_pkg.sv
// Shared constants and types for the machine-mode external interrupt controller.
package priv_1_12_irq_pkg;

    localparam int unsigned IRQ_ID_W   = 5;
    localparam int unsigned IRQ_ADDR_W = 6;

    // Register word indices on the MMIO register port
    localparam logic [IRQ_ADDR_W-1:0] IRQ_PENDING   = 6'd0;
    localparam logic [IRQ_ADDR_W-1:0] IRQ_ENABLE    = 6'd1;
    localparam logic [IRQ_ADDR_W-1:0] IRQ_THRESH    = 6'd2;
    localparam logic [IRQ_ADDR_W-1:0] IRQ_CLAIM     = 6'd3;
    localparam logic [IRQ_ADDR_W-1:0] IRQ_PRIO_BASE = 6'd4;

    typedef logic [IRQ_ID_W-1:0] irq_id_t;

    // Source index i is reported to software as ID i+1; ID 0 means "none"
    function automatic irq_id_t src_to_id(input int unsigned idx);
        return irq_id_t'(idx + 1);
    endfunction

endpackage

// File: rtl/priv_1_12_irq_arb.sv
// Combinational priority tree: highest priority wins, lower index wins ties.
module priv_1_12_irq_arb
    import priv_1_12_irq_pkg::*;
#(
    parameter int unsigned NUM_SRC = 8,
    parameter int unsigned PRIO_W  = 3
) (
    input  logic [NUM_SRC-1:0]             cand,
    input  logic [NUM_SRC-1:0][PRIO_W-1:0] prio,
    output irq_id_t                        win_id,
    output logic [PRIO_W-1:0]              win_prio
);

    localparam int unsigned LEVELS = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 0;
    localparam int unsigned LEAVES = 1 << LEVELS;
    localparam int unsigned NODES  = 2 * LEAVES;

    // Heap-ordered tree: node n has children 2n (lower indices) and 2n+1
    logic              node_vld  [1:NODES-1];
    irq_id_t           node_id   [1:NODES-1];
    logic [PRIO_W-1:0] node_prio [1:NODES-1];

    // Fill leaves, then reduce pairwise toward the root
    always_comb begin
        for (int n = 1; n < int'(NODES); n++) begin
            node_vld[n]  = 1'b0;
            node_id[n]   = '0;
            node_prio[n] = '0;
        end
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            node_vld[int'(LEAVES) + i]  = cand[i];
            node_id[int'(LEAVES) + i]   = src_to_id(i);
            node_prio[int'(LEAVES) + i] = prio[i];
        end
        for (int n = int'(LEAVES) - 1; n >= 1; n--) begin
            // Right child only wins on strictly higher priority
            if (node_vld[2*n+1] &&
                (!node_vld[2*n] || (node_prio[2*n+1] > node_prio[2*n]))) begin
                node_id[n]   = node_id[2*n+1];
                node_prio[n] = node_prio[2*n+1];
            end else begin
                node_id[n]   = node_id[2*n];
                node_prio[n] = node_prio[2*n];
            end
            node_vld[n] = node_vld[2*n] | node_vld[2*n+1];
        end
        win_id   = node_vld[1] ? node_id[1]   : '0;
        win_prio = node_vld[1] ? node_prio[1] : '0;
    end

endmodule

// File: rtl/priv_1_12_irq_ctrl.sv
// Machine-mode external interrupt controller: gateways, enables, priorities,
// threshold and claim/complete in front of the core's external interrupt input.
module priv_1_12_irq_ctrl
    import priv_1_12_irq_pkg::*;
#(
    parameter int unsigned        NUM_SRC     = 8,
    parameter int unsigned        PRIO_W      = 3,
    parameter logic [NUM_SRC-1:0] EDGE_MASK   = '0,
    parameter int unsigned        SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_SRC-1:0]    irq_src,
    input  logic                  reg_wen,
    input  logic                  reg_ren,
    input  logic [IRQ_ADDR_W-1:0] reg_addr,
    input  logic [31:0]           reg_wdata,
    output logic [31:0]           reg_rdata,
    output logic                  irq_m,
    output logic                  irq_clear
);

    logic [NUM_SRC-1:0]             s;
    logic [NUM_SRC-1:0]             s_prev;
    logic [NUM_SRC-1:0]             pending;
    logic [NUM_SRC-1:0]             in_service;
    logic [NUM_SRC-1:0]             enable;
    logic [PRIO_W-1:0]              threshold;
    logic [NUM_SRC-1:0][PRIO_W-1:0] prio;
    irq_id_t                        best_id;
    logic [PRIO_W-1:0]              best_prio;

    logic [NUM_SRC-1:0]    set_req;
    logic [NUM_SRC-1:0]    cand;
    logic [NUM_SRC-1:0]    claim_mask;
    logic [NUM_SRC-1:0]    complete_mask;
    logic [NUM_SRC-1:0]    prio_we;
    logic                  wr;
    logic                  rd;
    logic                  claim_hit;
    logic                  prio_sel;
    logic [IRQ_ADDR_W-1:0] prio_idx;
    irq_id_t               cmp_id;
    irq_id_t               arb_id;
    logic [PRIO_W-1:0]     arb_prio;
    logic [31:0]           rdata_d;

    // best_prio is kept for debug visibility; the register port does not expose it
    logic unused_bits;
    assign unused_bits = ^{best_prio, reg_wdata};

    // Input synchroniser chain on the asynchronous sources
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = irq_src;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0][NUM_SRC-1:0] sync_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= irq_src;
                    for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end
            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // Gateway set requests: rising edge for edge sources, level otherwise
    assign set_req = (s & ~s_prev & EDGE_MASK) | (s & ~EDGE_MASK);
    assign cand    = pending & enable & ~in_service & gate_prio(prio, threshold);
    assign cmp_id  = reg_wdata[IRQ_ID_W-1:0];

    function automatic logic [NUM_SRC-1:0] gate_prio(
        input logic [NUM_SRC-1:0][PRIO_W-1:0] p,
        input logic [PRIO_W-1:0]              thr
    );
        logic [NUM_SRC-1:0] above;
        above = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            above[i] = p[i] > thr;
        end
        return above;
    endfunction

    priv_1_12_irq_arb #(
        .NUM_SRC (NUM_SRC),
        .PRIO_W  (PRIO_W)
    ) u_arb (
        .cand     (cand),
        .prio     (prio),
        .win_id   (arb_id),
        .win_prio (arb_prio)
    );

    // Register-port decode: write wins over read, claim/complete masks, read mux
    always_comb begin
        wr            = reg_wen;
        rd            = reg_ren & ~reg_wen;
        claim_hit     = rd && (reg_addr == IRQ_CLAIM) && (best_id != '0);
        prio_idx      = reg_addr - IRQ_PRIO_BASE;
        prio_sel      = (reg_addr >= IRQ_PRIO_BASE) && (prio_idx < IRQ_ADDR_W'(NUM_SRC));
        claim_mask    = '0;
        complete_mask = '0;
        prio_we       = '0;
        rdata_d       = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            claim_mask[i]    = claim_hit && (best_id == src_to_id(i));
            complete_mask[i] = wr && (reg_addr == IRQ_CLAIM) &&
                               (cmp_id == src_to_id(i)) && in_service[i];
            prio_we[i]       = wr && prio_sel && (prio_idx == IRQ_ADDR_W'(i));
        end
        if (rd) begin
            case (reg_addr)
                IRQ_PENDING: rdata_d = 32'(pending);
                IRQ_ENABLE:  rdata_d = 32'(enable);
                IRQ_THRESH:  rdata_d = 32'(threshold);
                IRQ_CLAIM:   rdata_d = 32'(best_id);
                default: begin
                    for (int i = 0; i < int'(NUM_SRC); i++) begin
                        if (prio_sel && (prio_idx == IRQ_ADDR_W'(i))) begin
                            rdata_d = 32'(prio[i]);
                        end
                    end
                end
            endcase
        end
    end

    // Gateway/claim state, arbitration pipeline, configuration and read data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_prev     <= '0;
            pending    <= '0;
            in_service <= '0;
            enable     <= '0;
            threshold  <= '0;
            prio       <= '0;
            best_id    <= '0;
            best_prio  <= '0;
            irq_m      <= 1'b0;
            irq_clear  <= 1'b0;
            reg_rdata  <= '0;
        end else begin
            s_prev     <= s;
            pending    <= (pending | (set_req & ~in_service)) & ~claim_mask;
            in_service <= (in_service | claim_mask) & ~complete_mask;
            best_id    <= arb_id;
            best_prio  <= arb_prio;
            irq_m      <= arb_id != '0;
            irq_clear  <= claim_hit;
            reg_rdata  <= rdata_d;
            if (wr && (reg_addr == IRQ_ENABLE)) begin
                enable <= reg_wdata[NUM_SRC-1:0];
            end
            if (wr && (reg_addr == IRQ_THRESH)) begin
                threshold <= reg_wdata[PRIO_W-1:0];
            end
            for (int i = 0; i < int'(NUM_SRC); i++) begin
                if (prio_we[i]) begin
                    prio[i] <= reg_wdata[PRIO_W-1:0];
                end
            end
        end
    end

endmodule
